ahb_master_arbiter: RTL



---
 rtl/ahb_master_arbiter_pkg.sv | 32 +++
 rtl/ahb_burst_tracker.sv | 59 +++++
 rtl/ahb_master_arbiter.sv | 102 ++++++++++
 3 files changed

// File: rtl/ahb_master_arbiter_pkg.sv
// Shared AHB-Lite encodings for the two-master arbiter and its burst tracker.
package ahb_master_arbiter_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    localparam int BEAT_W = 4;

    // Beats still owed after the NONSEQ of a burst; undefined-length INCR
    // and SINGLE owe nothing, so they never block arbitration by count.
    function automatic logic [BEAT_W-1:0] beats_after_first(input logic [2:0] hburst);
        case (hburst)
            HBURST_SINGLE, HBURST_INCR:   return 4'd0;
            HBURST_WRAP4, HBURST_INCR4:   return 4'd3;
            HBURST_WRAP8, HBURST_INCR8:   return 4'd7;
            HBURST_WRAP16, HBURST_INCR16: return 4'd15;
            default:                      return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_burst_tracker.sv
// Tracks remaining fixed-length burst beats and the lock state of whichever
// master currently owns the address phase; exposes next-state values so the
// parent can decide handover in the same cycle.
module ahb_burst_tracker
    import ahb_master_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        htrans,
    input  logic [2:0]        hburst,
    input  logic              hmastlock,
    input  logic              hready,
    output logic [BEAT_W-1:0] beats_left_next,
    output logic              locked_next
);

    logic [BEAT_W-1:0] beats_left;
    logic              locked;
    logic              accept;

    assign accept = hready & htrans[1];

    // Load the burst length on NONSEQ, count down on SEQ, floor at zero.
    always_comb begin
        beats_left_next = beats_left;
        if (accept) begin
            if (htrans == HTRANS_NONSEQ) begin
                beats_left_next = beats_after_first(hburst);
            end else if (htrans == HTRANS_SEQ && beats_left != '0) begin
                beats_left_next = beats_left - 4'd1;
            end
        end
    end

    // Lock is taken by an accepted locked transfer and dropped by any
    // completed cycle where the owner has released HMASTLOCK.
    always_comb begin
        locked_next = locked;
        if (hready) begin
            if (accept && hmastlock) begin
                locked_next = 1'b1;
            end else if (!hmastlock) begin
                locked_next = 1'b0;
            end
        end
    end

    // State register; stalled cycles reproduce the current value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beats_left <= '0;
            locked     <= 1'b0;
        end else begin
            beats_left <= beats_left_next;
            locked     <= locked_next;
        end
    end

endmodule

// File: rtl/ahb_master_arbiter.sv
// Two-master AHB-Lite arbiter (CPU = master 0, DMA = master 1): address-phase
// grant, data-phase select and per-master HREADY gating, with handover only
// at burst/lock boundaries on a completed cycle.
module ahb_master_arbiter
    import ahb_master_arbiter_pkg::*;
#(
    parameter logic DEFAULT_MASTER = 1'b0,
    parameter logic ROUND_ROBIN    = 1'b1
)
(
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic [1:0] HTRANS_M0,
    input  logic [1:0] HTRANS_M1,
    input  logic [2:0] HBURST_M0,
    input  logic [2:0] HBURST_M1,
    input  logic       HMASTLOCK_M0,
    input  logic       HMASTLOCK_M1,
    input  logic       HREADY,
    output logic       grant_m0,
    output logic       grant_m1,
    output logic       data_sel,
    output logic       hready_m0,
    output logic       hready_m1
);

    logic              owner;
    logic              owner_next;
    logic              last_served;
    logic              last_served_next;
    logic [1:0]        own_htrans;
    logic [2:0]        own_hburst;
    logic              own_hmastlock;
    logic [BEAT_W-1:0] beats_left_next;
    logic              locked_next;
    logic              arb_point;
    logic              req_m0;
    logic              req_m1;

    assign own_htrans    = owner ? HTRANS_M1    : HTRANS_M0;
    assign own_hburst    = owner ? HBURST_M1    : HBURST_M0;
    assign own_hmastlock = owner ? HMASTLOCK_M1 : HMASTLOCK_M0;

    assign req_m0 = HTRANS_M0[1];
    assign req_m1 = HTRANS_M1[1];

    ahb_burst_tracker u_burst (
        .clk             (HCLK),
        .rst             (HRESET),
        .htrans          (own_htrans),
        .hburst          (own_hburst),
        .hmastlock       (own_hmastlock),
        .hready          (HREADY),
        .beats_left_next (beats_left_next),
        .locked_next     (locked_next)
    );

    // Round-robin must see this cycle's accepted NONSEQ, otherwise a
    // back-to-back SINGLE stream would hand the grant to the same master twice.
    assign last_served_next = (HREADY && own_htrans == HTRANS_NONSEQ) ? owner : last_served;

    assign arb_point = HREADY && (beats_left_next == '0) && !locked_next
                       && (own_htrans != HTRANS_BUSY);

    // Pick the next address-phase owner; park on the current owner when idle.
    always_comb begin
        owner_next = owner;
        if (arb_point) begin
            if (req_m0 && req_m1) begin
                owner_next = ROUND_ROBIN ? ~last_served_next : 1'b0;
            end else if (req_m0) begin
                owner_next = 1'b0;
            end else if (req_m1) begin
                owner_next = 1'b1;
            end
        end
    end

    // Owner, data-phase select and round-robin history.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            owner       <= DEFAULT_MASTER;
            data_sel    <= DEFAULT_MASTER;
            last_served <= DEFAULT_MASTER;
        end else begin
            owner       <= owner_next;
            last_served <= last_served_next;
            if (HREADY && own_htrans != HTRANS_IDLE) begin
                data_sel <= owner;
            end
        end
    end

    assign grant_m0 = ~owner;
    assign grant_m1 = owner;

    // A master that owns neither phase but is requesting is held off so it
    // keeps its address on the bus until granted.
    assign hready_m0 = (grant_m0 || data_sel == 1'b0) ? HREADY : ~HTRANS_M0[1];
    assign hready_m1 = (grant_m1 || data_sel == 1'b1) ? HREADY : ~HTRANS_M1[1];

endmodule
